nou_fifo_wr_packer: RTL and testbench



---
 rtl/nou_fifo_wr_packer.sv | 121 ++++++++++++
 tb/tb_nou_fifo_wr_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nou_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
//  Module      : nou_fifo_wr_packer
//  Description : Write-side feeder for the NOU output FIFO. Packs RATIO narrow
//                valid/ready beats into one wide word and pushes it through the
//                FIFO wr_en/wr_data/full interface. A last-flagged beat closes
//                the word early with zero padding in the unused upper lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module nou_fifo_wr_packer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] wr_data_o,
  output logic             wr_en_o,
  input  logic             full_i,
  output logic [31:0]      word_cnt_o,
  output logic             idle_o
);

  // Beats per word and the lane-index width. OUT_W/IN_W is a power of two >= 2,
  // so CW is at least 1 and cnt_q wraps naturally after lane RATIO-1.
  localparam int RATIO = OUT_W / IN_W;
  localparam int CW    = $clog2(RATIO);

  localparam logic [CW-1:0] C_LAST_LANE = CW'(RATIO - 1);

  // State
  logic [OUT_W-1:0] acc_q,      acc_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [OUT_W-1:0] out_q,      out_d;
  logic             out_vld_q,  out_vld_d;
  logic [31:0]      word_cnt_q, word_cnt_d;

  // Handshake terms
  logic w_wr_en;
  logic w_ready;
  logic w_accept;
  logic w_complete;

  // acc_q with the current lane replaced by the incoming beat, and the same
  // vector with every lane above the current one cleared (the closed word).
  logic [OUT_W-1:0] w_acc_ins;
  logic [OUT_W-1:0] w_merged;

  // A pending word is pushed whenever the FIFO has room; the input side is open
  // whenever the output register is empty or is being drained this cycle.
  assign w_wr_en    = out_vld_q & ~full_i;
  assign w_ready    = ~out_vld_q | ~full_i;
  assign w_accept   = in_valid_i & w_ready;
  assign w_complete = w_accept & ((cnt_q == C_LAST_LANE) | in_last_i);

  // Per-lane insert and zero-pad selection.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic w_is_cur;
    logic w_above;
    assign w_is_cur = (cnt_q == CW'(k));
    assign w_above  = (CW'(k) > cnt_q);

    assign w_acc_ins[k*IN_W +: IN_W] = w_is_cur ? in_data_i : acc_q[k*IN_W +: IN_W];
    assign w_merged[k*IN_W +: IN_W]  = w_above  ? {IN_W{1'b0}} : w_acc_ins[k*IN_W +: IN_W];
  end

  // Next-state: push path first, then a completing accept may reload out_q and
  // keep out_vld set for back-to-back words.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    word_cnt_d = word_cnt_q;

    if (w_wr_en) begin
      out_vld_d  = 1'b0;
      word_cnt_d = word_cnt_q + 32'd1;
    end

    if (w_accept) begin
      if (w_complete) begin
        out_d     = w_merged;
        out_vld_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = w_acc_ins;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset; reset drops any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign wr_en_o    = w_wr_en;
  assign wr_data_o  = out_q;
  assign in_ready_o = w_ready;
  assign word_cnt_o = word_cnt_q;
  assign idle_o     = (cnt_q == '0) & ~out_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_nou_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nou_fifo_wr_packer
//  Description : Scoreboarded bench for nou_fifo_wr_packer (IN_W=32, OUT_W=128).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nou_fifo_wr_packer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 128;
  localparam int RATIO = OUT_W / IN_W;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in_data_i;
  logic             in_valid_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [OUT_W-1:0] wr_data_o;
  logic             wr_en_o;
  logic             full_i;
  logic [31:0]      word_cnt_o;
  logic             idle_o;

  nou_fifo_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_last_i  (in_last_i),
    .in_ready_o (in_ready_o),
    .wr_data_o  (wr_data_o),
    .wr_en_o    (wr_en_o),
    .full_i     (full_i),
    .word_cnt_o (word_cnt_o),
    .idle_o     (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;
  int stalls;

  // Reference packer state and scoreboard
  logic [OUT_W-1:0] m_acc;
  int               m_cnt;
  int               m_pushed;
  logic [OUT_W-1:0] exp_q[$];
  int               wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference packer: called on each accepted beat.
  task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
    m_acc[m_cnt*IN_W +: IN_W] = d;
    if (l || m_cnt == RATIO - 1) begin
      exp_q.push_back(m_acc);
      m_pushed++;
      m_acc = '0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Output monitor: every FIFO write is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!rst && wr_en_o) begin
      chk("no_wr_while_full", {127'd0, full_i}, '0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", wr_data_o, 'x);
      end else begin
        chk("wr_data", wr_data_o, exp_q.pop_front());
      end
      wr_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_data_i  = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst      = 1'b0;
    exp_q.delete();
    m_acc    = '0;
    m_cnt    = 0;
    m_pushed = 0;
  endtask

  task automatic idle_cycles(input int n, input bit rnd_full);
    in_valid_i = 1'b0;
    repeat (n) begin
      if (rnd_full) full_i = ($urandom_range(0, 99) < 40);
      @(posedge clk); #1;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l, input bit rnd_full);
    bit done;
    done       = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rnd_full) full_i = ($urandom_range(0, 99) < 40);
      @(negedge clk);
      if (in_ready_o) begin
        model_accept(d, l);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", '0, 128'd1);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  initial begin
    int a_cyc;
    int base;
    int s0;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    stalls   = 0;
    full_i   = 1'b0;
    m_acc    = '0;
    m_cnt    = 0;
    m_pushed = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_wr_en",    {127'd0, wr_en_o},    '0);
    chk("rst_wr_data",  wr_data_o,            '0);
    chk("rst_in_ready", {127'd0, in_ready_o}, 128'd1);
    chk("rst_idle",     {127'd0, idle_o},     128'd1);
    chk("rst_word_cnt", {96'd0, word_cnt_o},  '0);
    @(posedge clk); #1;

    // Test 1: full word, latency of one cycle after the completing beat
    base = wr_cyc.size();
    send_beat(32'h11, 1'b0, 1'b0);
    send_beat(32'h22, 1'b0, 1'b0);
    send_beat(32'h33, 1'b0, 1'b0);
    send_beat(32'h44, 1'b0, 1'b0);
    a_cyc = cyc;
    chk("t1_exp_word", exp_q[0], 128'h00000044_00000033_00000022_00000011);
    idle_cycles(3, 1'b0);
    chk("t1_num_writes", 128'(wr_cyc.size() - base), 128'd1);
    if (wr_cyc.size() > base) chk("t1_latency", 128'(wr_cyc[base]), 128'(a_cyc));
    chk("t1_word_cnt", {96'd0, word_cnt_o}, 128'(m_pushed));
    chk("t1_idle", {127'd0, idle_o}, 128'd1);

    // Test 2: early close with last, next packet restarts at lane 0
    send_beat(32'hA, 1'b0, 1'b0);
    send_beat(32'hB, 1'b1, 1'b0);
    chk("t2_exp_word", exp_q[0], 128'h00000000_00000000_0000000B_0000000A);
    send_beat(32'hC, 1'b1, 1'b0);
    idle_cycles(3, 1'b0);
    chk("t2_word_cnt", {96'd0, word_cnt_o}, 128'(m_pushed));
    chk("t2_queue_empty", 128'(exp_q.size()), '0);

    // Test 3: 12 beats streamed, three writes 4 cycles apart, no stalls
    do_reset();
    base = wr_cyc.size();
    s0   = stalls;
    for (int i = 0; i < 12; i++) send_beat(32'h100 + i, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    chk("t3_no_stall", 128'(stalls - s0), '0);
    chk("t3_num_writes", 128'(wr_cyc.size() - base), 128'd3);
    if (wr_cyc.size() >= base + 3) begin
      chk("t3_gap0", 128'(wr_cyc[base+1] - wr_cyc[base]), 128'd4);
      chk("t3_gap1", 128'(wr_cyc[base+2] - wr_cyc[base+1]), 128'd4);
    end
    chk("t3_word_cnt", {96'd0, word_cnt_o}, 128'd3);

    // Test 4: word completes while FIFO full, held for 5 cycles
    send_beat(32'h5A0, 1'b0, 1'b0);
    send_beat(32'h5A1, 1'b0, 1'b0);
    send_beat(32'h5A2, 1'b0, 1'b0);
    full_i = 1'b1;
    send_beat(32'h5A3, 1'b0, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 32'hDEAD;
    repeat (5) begin
      @(negedge clk);
      chk("t4_wr_en_held",    {127'd0, wr_en_o},    '0);
      chk("t4_in_ready_held", {127'd0, in_ready_o}, '0);
      chk("t4_data_stable",   wr_data_o, 128'h000005A3_000005A2_000005A1_000005A0);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    full_i     = 1'b0;
    @(negedge clk);
    chk("t4_release_wr_en",    {127'd0, wr_en_o},    128'd1);
    chk("t4_release_in_ready", {127'd0, in_ready_o}, 128'd1);
    @(posedge clk); #1;
    idle_cycles(2, 1'b0);
    chk("t4_word_cnt", {96'd0, word_cnt_o}, 128'(m_pushed));

    // Test 5: reset mid-packet discards the partial word
    base = wr_cyc.size();
    send_beat(32'hEE, 1'b0, 1'b0);
    send_beat(32'hFF, 1'b0, 1'b0);
    do_reset();
    chk("t5_no_write", 128'(wr_cyc.size() - base), '0);
    chk("t5_word_cnt_rst", {96'd0, word_cnt_o}, '0);
    chk("t5_idle_rst", {127'd0, idle_o}, 128'd1);
    for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0, 1'b0);
    chk("t5_exp_word", exp_q[0], 128'h00000004_00000003_00000002_00000001);
    idle_cycles(3, 1'b0);
    chk("t5_word_cnt", {96'd0, word_cnt_o}, 128'd1);

    // Test 6: random valid gaps, random last, random full over 1000 beats
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
      send_beat($urandom(), (i == 999) || ($urandom_range(0, 7) == 0), 1'b1);
    end
    full_i = 1'b0;
    idle_cycles(5, 1'b0);
    chk("t6_queue_empty", 128'(exp_q.size()), '0);
    chk("t6_word_cnt", {96'd0, word_cnt_o}, 128'(m_pushed));
    chk("t6_idle", {127'd0, idle_o}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
